traffic_phase_sequencer: RTL and testbench

- Parametrised successor to the fixed-phase timer controller.
- Sequences N_PHASES traffic phases, each with a runtime-programmable duration in seconds, and prescales clk to a one-second tick.
- Exports the current phase index, the seconds-left countdown and a per-second decrement pulse to the display and VGA paths.
- Adds behaviour the fixed controller lacks: skipping zero-length phases, a pedestrian-request countdown cap, forced phase advance, and a run/pause enable.

---
 rtl/traffic_phase_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_traffic_phase_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_sequencer
// Brief    : Sequences N_PHASES traffic phases with runtime-programmable
//            durations, a one-second prescaler, zero-length phase skipping,
//            a pedestrian countdown cap, forced advance and run/pause.
//            Optional macro TLS_FLASH_EN adds a flashing (maintenance) state
//            driven by flash_mode, with a flash_on output.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_sequencer #(
    parameter int N_PHASES  = 4,
    parameter int PH_W      = 3,
    parameter int CNT_W     = 4,
    parameter int TICK_DIV  = 25000000,
    parameter int PED_PHASE = 2,
    parameter int PED_CAP   = 3
`ifdef TLS_FLASH_EN
    ,
    parameter int FLASH_PHASE = 1
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [N_PHASES*CNT_W-1:0] dur_flat,
    input  logic                      ped_req,
    input  logic                      force_next,
    output logic [PH_W-1:0]           cur_phase,
    output logic [CNT_W-1:0]          sec_left,
    output logic                      sec_tick,
    output logic                      phase_start,
    output logic                      ped_pending
`ifdef TLS_FLASH_EN
    ,
    input  logic                      flash_mode,
    output logic                      flash_on
`endif
);

    localparam int c_PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

`ifdef TLS_FLASH_EN
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLASH = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1
    } state_t;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_PS_W-1:0]   r_prescaler;
    logic [c_PS_W-1:0]   w_ps_nxt;
    logic [c_PS_W-1:0]   w_ps_inc;
    logic [PH_W-1:0]     w_phase_nxt;
    logic [PH_W-1:0]     w_next_phase;
    logic [CNT_W-1:0]    w_sec_nxt;
    logic [CNT_W-1:0]    w_cur_dur;
    logic                w_tick_nxt;
    logic                w_start_nxt;
    logic                w_ped_nxt;
    logic                w_ped_set;
    logic                w_wrap;
    logic                w_is_ped;
`ifdef TLS_FLASH_EN
    logic                w_flash_nxt;
`endif

    // State, counters and all registered outputs; reset acts immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_LOAD;
            r_prescaler <= '0;
            cur_phase   <= '0;
            sec_left    <= '0;
            sec_tick    <= 1'b0;
            phase_start <= 1'b0;
            ped_pending <= 1'b0;
`ifdef TLS_FLASH_EN
            flash_on    <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_prescaler <= w_ps_nxt;
            cur_phase   <= w_phase_nxt;
            sec_left    <= w_sec_nxt;
            sec_tick    <= w_tick_nxt;
            phase_start <= w_start_nxt;
            ped_pending <= w_ped_nxt;
`ifdef TLS_FLASH_EN
            flash_on    <= w_flash_nxt;
`endif
        end
    end

    // Next-state: phase loading/skipping, countdown, pedestrian cap, force
    always_comb begin
        w_state_nxt  = r_state;
        w_ps_nxt     = r_prescaler;
        w_phase_nxt  = cur_phase;
        w_sec_nxt    = sec_left;
        w_tick_nxt   = 1'b0;
        w_start_nxt  = 1'b0;
        w_cur_dur    = '0;
        w_next_phase = '0;
`ifdef TLS_FLASH_EN
        w_flash_nxt  = flash_on;
`endif

        // Duration of the current phase and its wrapping successor
        for (int i = 0; i < N_PHASES; i++) begin
            if (cur_phase == PH_W'(i)) begin
                w_cur_dur    = dur_flat[i*CNT_W +: CNT_W];
                w_next_phase = (i == N_PHASES - 1) ? '0 : PH_W'(i + 1);
            end
        end

        w_wrap   = (r_prescaler == c_PS_W'(TICK_DIV - 1));
        w_ps_inc = w_wrap ? '0 : r_prescaler + c_PS_W'(1);
        w_is_ped = (cur_phase == PH_W'(PED_PHASE));

        // Requests are latched even while paused; a request is already
        // being served when the pedestrian phase is running
        w_ped_set = ped_req && !(w_is_ped && (r_state == ST_RUN));
        w_ped_nxt = ped_pending || w_ped_set;

        if (en) begin
            case (r_state)
                ST_LOAD: begin
                    if (w_cur_dur != '0) begin
                        w_sec_nxt   = w_cur_dur;
                        w_ps_nxt    = '0;
                        w_start_nxt = 1'b1;
                        w_state_nxt = ST_RUN;
                        // Loading the pedestrian phase serves the request,
                        // including one arriving in this very cycle
                        if (w_is_ped) begin
                            w_ped_nxt = 1'b0;
                        end
                    end else begin
                        w_phase_nxt = w_next_phase;
                    end
                end
                ST_RUN: begin
                    w_ps_nxt = w_ps_inc;
                    if (force_next) begin
                        w_phase_nxt = w_next_phase;
                        w_sec_nxt   = '0;
                        w_ps_nxt    = '0;
                        w_state_nxt = ST_LOAD;
                    end else if (ped_req && !w_is_ped &&
                                 (sec_left > CNT_W'(PED_CAP))) begin
                        // Cap absorbs a coincident tick; prescaler keeps phase
                        w_sec_nxt = CNT_W'(PED_CAP);
                    end else if (w_wrap) begin
                        w_tick_nxt = 1'b1;
                        if (sec_left == CNT_W'(1)) begin
                            w_phase_nxt = w_next_phase;
                            w_sec_nxt   = '0;
                            w_state_nxt = ST_LOAD;
                        end else begin
                            w_sec_nxt = sec_left - CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end

`ifdef TLS_FLASH_EN
        // Flashing runs independently of en; leaving it restarts at phase 0
        if (r_state == ST_FLASH) begin
            w_ps_nxt = w_ps_inc;
            if (w_wrap) begin
                w_flash_nxt = !flash_on;
            end
            if (!flash_mode) begin
                w_state_nxt = ST_LOAD;
                w_phase_nxt = '0;
                w_sec_nxt   = '0;
                w_ps_nxt    = '0;
                w_flash_nxt = 1'b0;
            end
        end
        if (flash_mode) begin
            w_state_nxt = ST_FLASH;
            w_phase_nxt = PH_W'(FLASH_PHASE);
            w_sec_nxt   = '0;
            w_ps_nxt    = w_ps_inc;
            w_tick_nxt  = 1'b0;
            w_start_nxt = 1'b0;
            w_ped_nxt   = ped_pending || w_ped_set;
        end
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_phase_sequencer
// Brief    : Self-checking bench for traffic_phase_sequencer with a
//            behavioural reference model and randomized stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_sequencer;

    localparam int N_PHASES  = 4;
    localparam int PH_W      = 3;
    localparam int CNT_W     = 4;
    localparam int TICK_DIV  = 4;
    localparam int PED_PHASE = 2;
    localparam int PED_CAP   = 3;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      en = 1'b0;
    logic [N_PHASES*CNT_W-1:0] dur_flat = 16'h1203;
    logic                      ped_req = 1'b0;
    logic                      force_next = 1'b0;
    logic [PH_W-1:0]           cur_phase;
    logic [CNT_W-1:0]          sec_left;
    logic                      sec_tick;
    logic                      phase_start;
    logic                      ped_pending;

    traffic_phase_sequencer #(
        .N_PHASES (N_PHASES),
        .PH_W     (PH_W),
        .CNT_W    (CNT_W),
        .TICK_DIV (TICK_DIV),
        .PED_PHASE(PED_PHASE),
        .PED_CAP  (PED_CAP)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .dur_flat   (dur_flat),
        .ped_req    (ped_req),
        .force_next (force_next),
        .cur_phase  (cur_phase),
        .sec_left   (sec_left),
        .sec_tick   (sec_tick),
        .phase_start(phase_start),
        .ped_pending(ped_pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: "loading" flag, seconds shown, cycles elapsed in
    // the current second, and the pending-request flag
    int m_phase, m_left, m_sub;
    bit m_load, m_pend, m_tick, m_start;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int dur_of(input int p);
        logic [N_PHASES*CNT_W-1:0] d;
        d = dur_flat >> (p * CNT_W);
        return int'(d[CNT_W-1:0]);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_sub = 0;
        m_load = 1'b1; m_pend = 1'b0; m_tick = 1'b0; m_start = 1'b0;
    endtask

    // Advance the model by one clock using the inputs present at that edge
    task automatic model_step();
        int d;
        bit wrapped;
        m_tick  = 1'b0;
        m_start = 1'b0;
        if (ped_req && !(m_phase == PED_PHASE && !m_load)) m_pend = 1'b1;
        if (en) begin
            if (m_load) begin
                d = dur_of(m_phase);
                if (d != 0) begin
                    m_left  = d;
                    m_sub   = 0;
                    m_start = 1'b1;
                    m_load  = 1'b0;
                    if (m_phase == PED_PHASE) m_pend = 1'b0;
                end else begin
                    m_phase = (m_phase + 1) % N_PHASES;
                end
            end else if (force_next) begin
                m_phase = (m_phase + 1) % N_PHASES;
                m_left  = 0;
                m_sub   = 0;
                m_load  = 1'b1;
            end else begin
                wrapped = (m_sub + 1 == TICK_DIV);
                m_sub   = (m_sub + 1) % TICK_DIV;
                if (ped_req && m_phase != PED_PHASE && m_left > PED_CAP) begin
                    m_left = PED_CAP;
                end else if (wrapped) begin
                    m_tick = 1'b1;
                    if (m_left == 1) begin
                        m_phase = (m_phase + 1) % N_PHASES;
                        m_left  = 0;
                        m_load  = 1'b1;
                    end else begin
                        m_left = m_left - 1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("cur_phase",   int'(cur_phase),   m_phase);
        chk("sec_left",    int'(sec_left),    m_left);
        chk("sec_tick",    int'(sec_tick),    int'(m_tick));
        chk("phase_start", int'(phase_start), int'(m_start));
        chk("ped_pending", int'(ped_pending), int'(m_pend));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        compare_all();
    endtask

    initial begin
        int guard;
        int saved_sec;
        int p0;
        bit ok;

        model_reset();
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_phase", int'(cur_phase), 0);
        chk("rst_sec",   int'(sec_left), 0);
        chk("rst_tick",  int'(sec_tick), 0);
        chk("rst_start", int'(phase_start), 0);
        chk("rst_pend",  int'(ped_pending), 0);
        rst = 1'b0;
        en  = 1'b1;

        // First load, then the 3-2-1 countdown of phase 0
        step();
        chk("first_start", int'(phase_start), 1);
        chk("first_sec",   int'(sec_left), 3);
        repeat (4) step();
        chk("tick1_pulse", int'(sec_tick), 1);
        chk("tick1_sec",   int'(sec_left), 2);
        repeat (8) step();
        chk("tick3_phase", int'(cur_phase), 1);
        // Phase 1 skipped in one cycle, then phase 2 loads with 2 s
        repeat (2) step();
        chk("skip_start", int'(phase_start), 1);
        chk("skip_phase", int'(cur_phase), 2);
        chk("skip_sec",   int'(sec_left), 2);
        repeat (30) step();

        // Pedestrian cap in phase 0 with a 9 s duration
        dur_flat = 16'h1209;
        ok = 1'b0;
        for (guard = 0; guard < 200 && !ok; guard++) begin
            step();
            ok = m_start && m_phase == 0 && m_left == 9;
        end
        chk("wait_p0_9", int'(ok), 1);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        chk("ped_cap",  int'(sec_left), 3);
        chk("ped_set",  int'(ped_pending), 1);
        ok = 1'b0;
        for (guard = 0; guard < 200 && !ok; guard++) begin
            step();
            ok = m_start && m_phase == PED_PHASE;
        end
        chk("wait_p2", int'(ok), 1);
        chk("ped_clear", int'(ped_pending), 0);

        // Force coinciding with a tick in phase 0
        ok = 1'b0;
        for (guard = 0; guard < 300 && !ok; guard++) begin
            step();
            ok = !m_load && m_phase == 0 && m_sub == TICK_DIV - 1 && m_left > 1;
        end
        chk("wait_force", int'(ok), 1);
        force_next = 1'b1;
        step();
        force_next = 1'b0;
        chk("force_notick", int'(sec_tick), 0);
        chk("force_phase",  int'(cur_phase), 1);
        chk("force_sec",    int'(sec_left), 0);

        // Pause mid-phase with a request arriving while paused
        ok = 1'b0;
        for (guard = 0; guard < 300 && !ok; guard++) begin
            step();
            ok = !m_load && m_phase == 0 && m_left >= 2 && m_sub == 1;
        end
        chk("wait_pause", int'(ok), 1);
        saved_sec = int'(sec_left);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ped_req = (i == 5);
            step();
        end
        ped_req = 1'b0;
        en = 1'b1;
        chk("pause_sec",   int'(sec_left), saved_sec);
        chk("pause_phase", int'(cur_phase), 0);
        chk("pause_pend",  int'(ped_pending), 1);
        repeat (3) step();

        // Randomized operation against the model
        for (int i = 0; i < 3000; i++) begin
            en         = ($urandom_range(0, 9) != 0);
            ped_req    = ($urandom_range(0, 7) == 0);
            force_next = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 49) == 0) begin
                for (int p = 0; p < N_PHASES; p++) begin
                    dur_flat[p*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 6));
                end
            end
            step();
        end
        en = 1'b1; ped_req = 1'b0; force_next = 1'b0;

        // All durations zero: continuous skipping, no phase_start
        dur_flat = '0;
        ok = 1'b0;
        for (guard = 0; guard < 200 && !ok; guard++) begin
            step();
            ok = m_load;
        end
        chk("wait_zero", int'(ok), 1);
        p0 = int'(cur_phase);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("zero_cycle", int'(cur_phase), (p0 + k) % N_PHASES);
            chk("zero_nostart", int'(phase_start), 0);
        end

        // Asynchronous reset mid-cycle, with outputs driven non-zero first
        dur_flat = 16'h1209;
        repeat (6) step();
        @(posedge clk);
        #3;
        model_step();
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_phase", int'(cur_phase), 0);
        chk("arst_sec",   int'(sec_left), 0);
        chk("arst_tick",  int'(sec_tick), 0);
        chk("arst_start", int'(phase_start), 0);
        chk("arst_pend",  int'(ped_pending), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
